// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared owner encoding and sizing helpers for the data-memory port arbiter
package dmem_arb_pkg;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_UART = 1'b1
    } owner_e;

    localparam int STARVE_MAX_DEF = 8;

    // Counter width able to hold 0..max; at least one bit so a zero limit still builds.
    function automatic int starve_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of cycles a pending UART request has waited on a busy CPU
module arb_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEF,
    parameter int W   = starve_w(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic         sat,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign sat = (cnt_q == W'(MAX));
    assign cnt = cnt_q;

    // Clear wins over increment; increment stops once the limit is reached.
    always_comb begin
        cnt_d = clr ? '0 : (inc && !sat) ? cnt_q + W'(1) : cnt_q;
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the DataMemory port between the MEM stage and the UART loader
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_mem_read,
    input  logic              cpu_mem_write,
    input  logic [DATA_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    input  logic              uart_req,
    input  logic              uart_we,
    input  logic [DATA_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    output logic              uart_gnt,
    output logic              uart_rvalid,
    output logic [DATA_W-1:0] uart_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STARVE_W = starve_w(STARVE_MAX);

    owner_e              state_q, state_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                cpu_busy;
    logic                own_cpu;
    logic                go_uart;
    logic                starve_inc;
    logic                starve_clr;
    logic                starve_sat;
    logic [STARVE_W-1:0] starve_cnt;

    assign cpu_busy    = cpu_mem_read | cpu_mem_write;
    assign own_cpu     = (state_q == OWN_CPU);
    assign uart_rvalid = rvalid_q;
    assign uart_rdata  = rdata_q;

    // Starvation only accrues while the CPU holds the port against a waiting UART.
    arb_starve_counter #(
        .MAX (STARVE_MAX),
        .W   (STARVE_W)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat),
        .cnt   (starve_cnt)
    );

    // Next owner and the memory-side mux; a UART grant always lasts exactly one cycle.
    always_comb begin
        go_uart    = uart_req && (!cpu_busy || starve_sat);
        starve_inc = own_cpu && uart_req && cpu_busy;
        starve_clr = !uart_req || (own_cpu && go_uart);
        state_d    = (own_cpu && go_uart) ? OWN_UART : OWN_CPU;
        uart_gnt   = !own_cpu;
        cpu_stall  = !own_cpu && cpu_busy;
        mem_write  = own_cpu ? cpu_mem_write : uart_we;
        mem_read   = own_cpu ? (cpu_mem_read && !cpu_mem_write) : !uart_we;
        mem_addr   = own_cpu ? cpu_addr : uart_addr;
        mem_wdata  = own_cpu ? cpu_wdata : uart_wdata;
    end

    // UART read data is captured on the grant edge and flagged valid for one cycle.
    always_comb begin
        rvalid_d = !own_cpu && !uart_we;
        rdata_d  = rvalid_d ? mem_rdata : rdata_q;
    end

    // Owner and read-capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OWN_CPU;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    logic unused_cnt;
    assign unused_cnt = ^starve_cnt;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vector and sequence checks of the data-memory port arbiter
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_mem_read, cpu_mem_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall;
    logic        uart_req, uart_we;
    logic [31:0] uart_addr, uart_wdata;
    logic        uart_gnt, uart_rvalid;
    logic [31:0] uart_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_W(32), .STARVE_MAX(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_mem_read  (cpu_mem_read),
        .cpu_mem_write (cpu_mem_write),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_stall     (cpu_stall),
        .uart_req      (uart_req),
        .uart_we       (uart_we),
        .uart_addr     (uart_addr),
        .uart_wdata    (uart_wdata),
        .uart_gnt      (uart_gnt),
        .uart_rvalid   (uart_rvalid),
        .uart_rdata    (uart_rdata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

    typedef struct {
        logic        rd, wr;
        logic [31:0] ca, cd;
        logic        rq, we;
        logic [31:0] ua, ud;
        logic [100:0] exp;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [100:0] ex(input logic st, g, rv, input logic [31:0] rdt,
                                        input logic mr, mw, input logic [31:0] ma, md);
        return {st, g, rv, rdt, mr, mw, ma, md};
    endfunction

    function automatic vec_t mk(input logic rd, wr, input logic [31:0] ca, cd,
                                input logic rq, we, input logic [31:0] ua, ud,
                                input logic [100:0] e);
        vec_t v;
        v.rd = rd; v.wr = wr; v.ca = ca; v.cd = cd;
        v.rq = rq; v.we = we; v.ua = ua; v.ud = ud; v.exp = e;
        return v;
    endfunction

    function automatic logic [100:0] outs();
        return {cpu_stall, uart_gnt, uart_rvalid, uart_rdata, mem_read, mem_write, mem_addr, mem_wdata};
    endfunction

    task automatic chk(input string nm, input logic [100:0] act, input logic [100:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rd, wr, input logic [31:0] ca, cd,
                         input logic rq, we, input logic [31:0] ua, ud);
        cpu_mem_read = rd; cpu_mem_write = wr; cpu_addr = ca; cpu_wdata = cd;
        uart_req = rq; uart_we = we; uart_addr = ua; uart_wdata = ud;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the current cycle; returns the cycle index of the first grant, 0 if none.
    task automatic wait_gnt(input int lim, output int n, output int route_bad);
        n = 0;
        route_bad = 0;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (uart_gnt) begin
                n = i;
                return;
            end
            if (cpu_stall || mem_addr !== cpu_addr ||
                mem_read !== (cpu_mem_read & ~cpu_mem_write) || mem_write !== cpu_mem_write)
                route_bad++;
            next_cycle();
        end
    endtask

    int n, bad;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        vecs[0]  = mk(1,0,32'h10,0, 0,0,0,0,               ex(0,0,0,0,            1,0,32'h10,0));
        vecs[1]  = mk(0,0,32'h20,0, 1,1,32'h40,32'hDEADBEEF, ex(0,0,0,0,           0,0,32'h20,0));
        vecs[2]  = mk(0,0,32'h20,0, 1,1,32'h40,32'hDEADBEEF, ex(0,1,0,0,           0,1,32'h40,32'hDEADBEEF));
        vecs[3]  = mk(1,1,32'h80,32'h11, 0,0,0,0,          ex(0,0,0,0,            0,1,32'h80,32'h11));
        vecs[4]  = mk(0,0,0,0, 1,0,32'h40,0,               ex(0,0,0,0,            0,0,0,0));
        vecs[5]  = mk(0,0,0,0, 1,0,32'h40,0,               ex(0,1,0,0,            1,0,32'h40,0));
        vecs[6]  = mk(0,0,0,0, 0,0,0,0,                    ex(0,0,1,32'hDEADBEEF, 0,0,0,0));
        vecs[7]  = mk(0,0,0,0, 0,0,0,0,                    ex(0,0,0,32'hDEADBEEF, 0,0,0,0));
        vecs[8]  = mk(0,0,0,0, 1,0,32'h80,0,               ex(0,0,0,32'hDEADBEEF, 0,0,0,0));
        vecs[9]  = mk(0,0,0,0, 1,0,32'h80,0,               ex(0,1,0,32'hDEADBEEF, 1,0,32'h80,0));
        vecs[10] = mk(0,0,0,0, 0,0,0,0,                    ex(0,0,1,32'h11,       0,0,0,0));
        vecs[11] = mk(1,0,32'h44,0, 1,1,32'hC0,5,          ex(0,0,0,32'h11,       1,0,32'h44,0));
        vecs[12] = mk(0,0,0,0, 1,1,32'hC0,5,               ex(0,0,0,32'h11,       0,0,0,0));
        vecs[13] = mk(0,1,32'h48,7, 1,1,32'hC0,5,          ex(1,1,0,32'h11,       0,1,32'hC0,5));
        vecs[14] = mk(0,0,0,0, 0,0,0,0,                    ex(0,0,0,32'h11,       0,0,0,0));

        rst_n = 1'b0;
        drive(0,0,32'h14,32'h3, 0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), ex(0,0,0,0, 0,0,32'h14,32'h3));
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].ca, vecs[i].cd,
                  vecs[i].rq, vecs[i].we, vecs[i].ua, vecs[i].ud);
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
            next_cycle();
        end

        // Busy CPU with a held UART read: forced grant on the 10th cycle, then re-arbitration.
        drive(1,0,32'h40,0, 1,0,32'h80,0);
        wait_gnt(20, n, bad);
        chk("starve_latency", n, 10);
        chk("starve_route", bad, 0);
        chk("starve_grant_cycle", {cpu_stall, mem_read, mem_write, mem_addr}, {3'b110, 32'h80});
        next_cycle();
        @(negedge clk);
        chk("starve_rvalid", {uart_rvalid, uart_rdata, cpu_stall, uart_gnt, mem_rdata},
            {1'b1, 32'h11, 2'b00, 32'hDEADBEEF});
        next_cycle();
        wait_gnt(20, n, bad);
        chk("b2b_spacing", n + 1, 10);
        chk("b2b_route", bad, 0);
        next_cycle();
        drive(0,0,0,0, 0,0,0,0);
        next_cycle();

        // Request withdrawn after 3 starved cycles: no access, and the count restarts.
        drive(1,0,32'h40,0, 1,1,32'h100,32'hAA);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (uart_gnt || mem_addr !== 32'h40) bad++;
            next_cycle();
        end
        uart_req = 1'b0;
        @(negedge clk);
        if (uart_gnt || mem_write) bad++;
        chk("withdraw_no_access", bad, 0);
        next_cycle();
        uart_req = 1'b1;
        wait_gnt(20, n, bad);
        chk("withdraw_restart_latency", n, 10);
        chk("withdraw_grant_cycle", {cpu_stall, mem_write, mem_addr, mem_wdata}, {2'b11, 32'h100, 32'hAA});
        next_cycle();
        drive(0,0,0,0, 0,0,0,0);
        next_cycle();

        // Reset asserted during a UART write grant drops it; the write never lands.
        drive(0,0,32'h24,0, 1,1,32'h40,32'hBAD);
        next_cycle();
        @(negedge clk);
        chk("pre_reset_grant", {uart_gnt, mem_write, mem_addr}, {2'b11, 32'h40});
        #1 rst_n = 1'b0;
        #1 chk("reset_mid_grant", outs(), ex(0,0,0,0, 0,0,32'h24,0));
        uart_req = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        drive(0,0,0,0, 1,0,32'h40,0);
        wait_gnt(5, n, bad);
        chk("idle_latency_after_reset", n, 2);
        next_cycle();
        uart_req = 1'b0;
        @(negedge clk);
        chk("no_partial_write", {uart_rvalid, uart_rdata}, {1'b1, 32'hDEADBEEF});
        next_cycle();
        @(negedge clk);
        chk("rvalid_one_cycle", {uart_rvalid, uart_rdata}, {1'b0, 32'hDEADBEEF});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
